parent_link_arbiter: RTL and testbench



---
 rtl/helios_link_pkg.sv | 27 ++
 rtl/link_skid_buffer.sv | 61 ++++++
 rtl/parent_link_arbiter.sv | 106 ++++++++++
 tb/tb_parent_link_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/helios_link_pkg.sv
// Shared definitions for the parent link: arbiter state type, link word
// width and the cyclic priority search used to pick the next requester.
package helios_link_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int LINK_WORD_WIDTH = 64;

  // Returns the first index i (0..n-1) with valid[i] set, searching upward
  // from ptr and wrapping at n. Returns -1 when nothing is valid.
  // The loop runs over a fixed 32 positions so it unrolls to static logic.
  function automatic int rr_pick(input logic [31:0] valid, input int n, input int ptr);
    int idx;
    rr_pick = -1;
    for (int k = 31; k >= 0; k--) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/link_skid_buffer.sv
// Two-entry FIFO with a registered head word. Accepts one word and emits one
// word per cycle; in_ready depends only on the stored count, never on
// out_ready, so the upstream ready path stays short.
module link_skid_buffer
  import helios_link_pkg::*;
#(
  parameter int WIDTH = LINK_WORD_WIDTH + 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic             push;
  logic             pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Head/tail storage and occupancy; head keeps its last word when emptied.
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd1) begin
            head <= in_data;
          end else begin
            head <= tail;
            tail <= in_data;
          end
        end
        2'b10: begin
          if (count == 2'd0) head <= in_data;
          else               tail <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          if (count == 2'd2) head <= tail;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/parent_link_arbiter.sv
// Round-robin arbiter sharing the parent transmit link among word-stream
// requesters. A grant is held for up to MAX_BURST words while the owner keeps
// valid asserted; re-arbitration happens in the cycle the lock ends.
module parent_link_arbiter
  import helios_link_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = LINK_WORD_WIDTH,
  parameter int MAX_BURST  = 4,
  localparam int REQ_ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [REQ_ID_WIDTH-1:0]       out_src,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t              state;
  logic [REQ_ID_WIDTH-1:0] owner;
  logic [REQ_ID_WIDTH-1:0] rr_ptr;
  logic [CNT_W-1:0]        burst_cnt;

  logic                    locked;
  logic                    has_winner;
  logic [REQ_ID_WIDTH-1:0] winner;
  logic [DATA_WIDTH-1:0]   win_data;
  logic                    xfer;
  logic                    buf_in_ready;
  logic [1:0]              buf_count;
  int                      pick;

  assign locked = (state == BURST) && req_valid[owner] && (burst_cnt < MAX_CNT);
  assign xfer   = |(req_valid & req_ready);
  assign busy   = (buf_count != 2'd0) || (|req_valid) || (state == BURST);

  // Winner selection: the owner while locked, else cyclic search from rr_ptr.
  always_comb begin
    pick       = rr_pick(32'(req_valid), NUM_REQ, int'(rr_ptr));
    has_winner = 1'b0;
    winner     = '0;
    if (locked) begin
      has_winner = 1'b1;
      winner     = owner;
    end else if (pick >= 0) begin
      has_winner = 1'b1;
      winner     = REQ_ID_WIDTH'(pick);
    end
  end

  // Ready decode and data mux for the winning requester.
  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == REQ_ID_WIDTH'(i)) begin
        win_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        req_ready[i] = has_winner && buf_in_ready && !reset;
      end
    end
  end

  // Grant FSM: new grants reload the burst counter and advance rr_ptr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      burst_cnt <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      if (locked) begin
        burst_cnt <= burst_cnt + 1'b1;
      end else begin
        state     <= BURST;
        owner     <= winner;
        burst_cnt <= CNT_W'(1);
        rr_ptr    <= (winner == REQ_ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
      end
    end else if (!locked) begin
      state <= IDLE;
    end
  end

  link_skid_buffer #(
    .WIDTH(DATA_WIDTH + REQ_ID_WIDTH)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({winner, win_data}),
    .in_valid (xfer),
    .in_ready (buf_in_ready),
    .out_data ({out_src, out_data}),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count    (buf_count)
  );

endmodule

// File: tb/tb_parent_link_arbiter.sv
// Bench for parent_link_arbiter: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_parent_link_arbiter;

  localparam int NR   = 3;
  localparam int DW   = 64;
  localparam int MAXB = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    out_data;
  logic [IDW-1:0]   out_src;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  parent_link_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MAXB)
  ) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_ready(req_ready), .out_data(out_data), .out_src(out_src),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference model state
  bit                m_burst;
  int                m_owner, m_cnt, m_ptr;
  logic [IDW+DW-1:0] m_buf[$];
  logic [IDW+DW-1:0] m_hold;
  logic [NR-1:0]     last_acc;

  // stimulus control
  logic [DW-1:0] src_q[NR][$];
  int            pv[NR];
  bit            fill[NR];

  // observation logs (DUT side)
  int            acc_src[$], acc_cyc[$], del_src[$], del_cyc[$];
  logic [DW-1:0] del_data[$];

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic model_reset();
    m_burst = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    m_buf.delete(); m_hold = '0; last_acc = '0;
  endtask

  task automatic clear_logs();
    acc_src.delete(); acc_cyc.delete();
    del_src.delete(); del_cyc.delete(); del_data.delete();
  endtask

  // One clock: compare at the falling edge, advance the model after the rising edge.
  task automatic cycle();
    int                cnt, win, idx;
    bit                lock, xfer, pop;
    logic [NR-1:0]     exp_rdy;
    logic [IDW+DW-1:0] head, word;
    @(negedge clk);
    cnt  = m_buf.size();
    lock = m_burst && req_valid[m_owner] && (m_cnt < MAXB);
    win  = -1;
    if (lock) win = m_owner;
    else begin
      for (int k = 0; k < NR; k++) begin
        idx = (m_ptr + k) % NR;
        if (win < 0 && req_valid[idx]) win = idx;
      end
    end
    exp_rdy = '0;
    if (!reset && cnt < 2 && win >= 0) exp_rdy[win] = 1'b1;
    head = (cnt > 0) ? m_buf[0] : m_hold;
    chk("req_ready", 80'(req_ready), 80'(exp_rdy));
    chk("out_valid", 80'(out_valid), 80'(cnt > 0));
    chk("out_data",  80'(out_data),  80'(head[DW-1:0]));
    chk("out_src",   80'(out_src),   80'(head[IDW+DW-1:DW]));
    chk("busy",      80'(busy),      80'((cnt > 0) || (|req_valid) || m_burst));
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) begin acc_src.push_back(i); acc_cyc.push_back(cyc); end
    if (out_valid && out_ready) begin
      del_src.push_back(int'(out_src)); del_cyc.push_back(cyc); del_data.push_back(out_data);
    end
    xfer = (exp_rdy != '0);
    pop  = (cnt > 0) && out_ready;
    word = '0;
    if (xfer) word = {IDW'(win), req_data[win*DW +: DW]};
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      last_acc = exp_rdy & req_valid;
      if (pop) m_hold = m_buf.pop_front();
      if (xfer) begin
        m_buf.push_back(word);
        if (lock) m_cnt++;
        else begin
          m_owner = win; m_cnt = 1; m_ptr = (win + 1) % NR; m_burst = 1;
        end
      end else if (!lock) begin
        m_burst = 0;
      end
    end
  endtask

  // Present next words; a word not yet accepted is held unchanged.
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (req_valid[i] && !last_acc[i]) continue;
      if ((src_q[i].size() > 0 || fill[i]) && $urandom_range(99) < pv[i]) begin
        req_valid[i] = 1'b1;
        if (src_q[i].size() > 0) req_data[i*DW +: DW] = src_q[i].pop_front();
        else                     req_data[i*DW +: DW] = {$urandom, $urandom};
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin drive(); cycle(); end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    reset     = 1'b0;
    req_valid = '0;
    last_acc  = '0;
  endtask

  task automatic set_all(input int p, input bit f);
    for (int i = 0; i < NR; i++) begin pv[i] = p; fill[i] = f; end
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b0;
    set_all(0, 0);
    @(posedge clk); #1;
    model_reset();

    // reset held with all requesters valid
    req_valid = '1;
    do_reset(3);
    chk("rst_rr_ptr", 80'(dut.rr_ptr), 80'(0));
    chk("rst_state",  80'(dut.state),  80'(0));

    // single source, three back-to-back words
    out_ready = 1'b1;
    src_q[1].push_back(64'hA1); src_q[1].push_back(64'hA2); src_q[1].push_back(64'hA3);
    pv[1] = 100;
    clear_logs();
    run(5);
    chk("single_cnt", 80'(del_data.size()), 80'(3));
    if (del_data.size() == 3 && acc_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        chk("single_data", 80'(del_data[k]), 80'(64'hA1 + k));
        chk("single_src",  80'(del_src[k]),  80'(1));
        chk("single_lat",  80'(del_cyc[k]),  80'(acc_cyc[k] + 1));
      end
      chk("single_gap", 80'(del_cyc[2] - del_cyc[0]), 80'(2));
    end

    // full contention from a clean reset
    do_reset(1);
    set_all(100, 1);
    clear_logs();
    run(14);
    chk("cont_cnt", 80'(del_src.size() >= 12), 80'(1));
    if (del_src.size() >= 12) begin
      for (int k = 0; k < 12; k++) chk("cont_src", 80'(del_src[k]), 80'((k / 4) % 3));
      chk("cont_rate", 80'(del_cyc[11] - del_cyc[0]), 80'(11));
    end

    // backpressure on a single requester
    set_all(0, 0);
    run(6);
    clear_logs();
    for (int k = 0; k < 5; k++) src_q[0].push_back(64'hD000_0000_0000_0000 + k);
    pv[0] = 100;
    out_ready = 1'b0;
    run(5);
    chk("bp_accepts", 80'(acc_src.size()), 80'(2));
    chk("bp_ready",   80'(req_ready),      80'(0));
    out_ready = 1'b1;
    run(10);
    chk("bp_delivered", 80'(del_data.size()), 80'(5));
    if (del_data.size() == 5)
      for (int k = 0; k < 5; k++) chk("bp_order", 80'(del_data[k]), 80'(64'hD000_0000_0000_0000 + k));

    // early release: req0 sends two words, req2 waiting
    do_reset(1);
    set_all(0, 0);
    src_q[0].push_back(64'hE1); src_q[0].push_back(64'hE2);
    pv[0] = 100; pv[2] = 100; fill[2] = 1;
    clear_logs();
    run(3);
    chk("early_cnt", 80'(acc_src.size()), 80'(3));
    if (acc_src.size() == 3) begin
      chk("early_a0",  80'(acc_src[0]), 80'(0));
      chk("early_a1",  80'(acc_src[1]), 80'(0));
      chk("early_a2",  80'(acc_src[2]), 80'(2));
      chk("early_gap", 80'(acc_cyc[2] - acc_cyc[1]), 80'(1));
    end
    chk("early_rr_ptr", 80'(dut.rr_ptr), 80'(0));
    run(3);

    // reset mid-burst with a full buffer
    set_all(100, 1);
    out_ready = 1'b0;
    run(4);
    chk("full_ready", 80'(req_ready), 80'(0));
    do_reset(1);
    chk("mid_rst_state", 80'(dut.state), 80'(0));
    chk("mid_rst_valid", 80'(out_valid), 80'(0));
    pv[0] = 0; fill[0] = 0;
    out_ready = 1'b1;
    clear_logs();
    run(1);
    chk("mid_rst_first", 80'(acc_src.size() > 0 ? acc_src[0] : -1), 80'(1));

    // randomized traffic
    repeat (16) begin
      for (int i = 0; i < NR; i++) begin pv[i] = $urandom_range(20, 100); fill[i] = 1; end
      repeat (50) begin
        out_ready = ($urandom_range(99) < 70);
        drive();
        cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
